// File: rtl/fp_truncate_scheduler.sv
// Round-robin shared fixed-point truncate/saturate unit: NREQ requesters feed one
// floor-rounding converter with a one-entry registered result and a saturation counter.
module fp_truncate_scheduler #(
   parameter int NREQ          = 4,
   parameter int IIBITS        = 24,
   parameter int IFBITS        = 40,
   parameter int OIBITS        = 12,
   parameter int OFBITS        = 20,
   parameter int SIGNED_VALUES = 1,
   parameter int SATCNT_BITS   = 16,
   localparam int IW  = IIBITS + IFBITS,
   localparam int OW  = OIBITS + OFBITS,
   localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic                   i_clk,
   input  logic                   i_reset,
   input  logic [NREQ-1:0]        i_req_valid,
   output logic [NREQ-1:0]        o_req_ready,
   input  logic [NREQ*IW-1:0]     i_req_value,
   output logic                   o_out_valid,
   input  logic                   i_out_ready,
   output logic [OW-1:0]          o_out_value,
   output logic [IDW-1:0]         o_out_id,
   output logic                   o_out_saturated,
   input  logic                   i_sat_clear,
   output logic [SATCNT_BITS-1:0] o_sat_count
);

   localparam int SH = IFBITS - OFBITS;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_HOLD    = 2'd2
   } state_t;

   state_t                 r_state;
   logic [IDW-1:0]         r_rr_ptr;
   logic [IW-1:0]          r_operand;
   logic [IDW-1:0]         r_cap_id;
   logic                   r_out_valid;
   logic [OW-1:0]          r_out_value;
   logic [IDW-1:0]         r_out_id;
   logic                   r_out_saturated;
   logic [SATCNT_BITS-1:0] r_sat_count;

   logic                   w_grant_any;
   logic [IDW-1:0]         w_grant_id;
   logic                   w_slot_open;
   logic                   w_accept;
   logic [IDW-1:0]         w_rr_next;
   logic [OW:0]            w_conv;

   // Returns {saturated, value}: floor shift, then clamp when the narrow view cannot represent it.
   function automatic logic [OW:0] f_convert(input logic [IW-1:0] v);
      logic [IW-1:0] r;
      logic [IW-1:0] back;
      if (SIGNED_VALUES != 0) begin
         r    = IW'($signed(v) >>> SH);
         back = IW'($signed(r[OW-1:0]));
      end else begin
         r    = v >> SH;
         back = IW'(r[OW-1:0]);
      end
      if (back == r)
         f_convert = {1'b0, r[OW-1:0]};
      else if ((SIGNED_VALUES != 0) && r[IW-1])
         f_convert = {1'b1, 1'b1, {(OW-1){1'b0}}};
      else if (SIGNED_VALUES != 0)
         f_convert = {1'b1, 1'b0, {(OW-1){1'b1}}};
      else
         f_convert = {1'b1, {OW{1'b1}}};
   endfunction

   // Round-robin search starting at r_rr_ptr.
   always_comb begin
      w_grant_any = 1'b0;
      w_grant_id  = '0;
      for (int k = 0; k < NREQ; k++) begin
         logic [IDW-1:0] idx;
         idx = IDW'((int'(r_rr_ptr) + k) % NREQ);
         if (!w_grant_any && i_req_valid[idx]) begin
            w_grant_any = 1'b1;
            w_grant_id  = idx;
         end else begin
            w_grant_any = w_grant_any;
         end
      end
   end

   assign w_slot_open = !i_reset && ((r_state == S_IDLE) || ((r_state == S_HOLD) && i_out_ready));
   assign w_accept    = w_slot_open && w_grant_any;
   assign w_rr_next   = (w_grant_id == IDW'(NREQ - 1)) ? '0 : w_grant_id + IDW'(1);
   assign w_conv      = f_convert(r_operand);

   // One-hot combinational grant strobe.
   always_comb begin
      o_req_ready = '0;
      if (w_accept)
         o_req_ready = NREQ'(1) << w_grant_id;
      else
         o_req_ready = '0;
   end

   // Controller, capture register, result register and saturation counter.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= S_IDLE;
         r_rr_ptr        <= '0;
         r_operand       <= '0;
         r_cap_id        <= '0;
         r_out_valid     <= 1'b0;
         r_out_value     <= '0;
         r_out_id        <= '0;
         r_out_saturated <= 1'b0;
         r_sat_count     <= '0;
      end else begin
         if (i_sat_clear)
            r_sat_count <= '0;
         else if (r_out_valid && i_out_ready && r_out_saturated && (r_sat_count != '1))
            r_sat_count <= r_sat_count + SATCNT_BITS'(1);

         if (w_accept) begin
            r_operand <= i_req_value[int'(w_grant_id)*IW +: IW];
            r_cap_id  <= w_grant_id;
            r_rr_ptr  <= w_rr_next;
         end

         case (r_state)
            S_IDLE: begin
               if (w_accept)
                  r_state <= S_CONVERT;
            end
            S_CONVERT: begin
               r_out_saturated <= w_conv[OW];
               r_out_value     <= w_conv[OW-1:0];
               r_out_id        <= r_cap_id;
               r_out_valid     <= 1'b1;
               r_state         <= S_HOLD;
            end
            S_HOLD: begin
               if (i_out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= w_accept ? S_CONVERT : S_IDLE;
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign o_out_valid     = r_out_valid;
   assign o_out_value     = r_out_value;
   assign o_out_id        = r_out_id;
   assign o_out_saturated = r_out_saturated;
   assign o_sat_count     = r_sat_count;

endmodule
